rr_req_4: RTL

RR_REQ_4 -- requirements
Module: rr_req_4

---
 rtl/rr_req_4.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/rr_req_4.sv
// rr_req_4: descriptor-driven packet requester for a round-robin scheduler.
//
// Descriptors {dest, len} are queued in a small FIFO. One at a time the head
// descriptor is popped; the block raises a one-hot request toward the
// scheduler for its destination port. Once granted, it holds the grant
// (stall) and streams len+1 words downstream under tx_ready backpressure.
// Then it drops the request for one cycle so the scheduler can rotate.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr           synchronous flush (queue, FSM, beat counter, err; not pkt_cnt)
//   desc_valid    descriptor offered
//   desc_dest     destination port index
//   desc_len      packet length in words minus one
//   desc_ready    queue not full
//   req           one-hot request to scheduler
//   grant         one-hot grant from scheduler
//   stall         hold-grant while a transfer is in progress
//   tx_valid      word transferred this cycle when tx_ready is high
//   tx_ready      downstream backpressure
//   tx_last       final word of the packet, qualified by tx_valid
//   pkt_cnt       completed-packet counter, wraps
//   err           sticky protocol error flag
module rr_req_4 #(
    parameter int GSIZE     = 4,
    parameter int LOG_GSIZE = 2,
    parameter int LWIDTH    = 8,
    parameter int QDEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 desc_valid,
    input  logic [LOG_GSIZE-1:0] desc_dest,
    input  logic [LWIDTH-1:0]    desc_len,
    output logic                 desc_ready,
    output logic [GSIZE-1:0]     req,
    input  logic [GSIZE-1:0]     grant,
    output logic                 stall,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 tx_last,
    output logic [15:0]          pkt_cnt,
    output logic                 err
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = LWIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    // One-hot decode of a destination index.
    function automatic logic [GSIZE-1:0] dest_onehot(input logic [LOG_GSIZE-1:0] idx);
        logic [GSIZE-1:0] v;
        for (int i = 0; i < GSIZE; i++) begin
            v[i] = (idx == LOG_GSIZE'(i));
        end
        return v;
    endfunction

    state_t                 state_q,    state_d;
    logic [LOG_GSIZE-1:0]   cur_dest_q, cur_dest_d;
    logic [LWIDTH-1:0]      cur_len_q,  cur_len_d;
    logic [BW-1:0]          beat_q,     beat_d;
    logic [15:0]            pkt_cnt_q,  pkt_cnt_d;
    logic                   err_q,      err_d;
    logic [PW-1:0]          wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]          count_q,    count_d;

    logic [LOG_GSIZE-1:0]   mem_dest_q [QDEPTH];
    logic [LWIDTH-1:0]      mem_len_q  [QDEPTH];

    logic                   full_s;
    logic                   empty_s;
    logic                   dest_ok_s;
    logic                   accept_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   busy_s;
    logic [GSIZE-1:0]       req_vec_s;
    logic                   grant_cur_s;
    logic                   grant_other_s;
    logic                   tx_valid_s;
    logic                   beat_acc_s;
    logic                   last_s;
    logic                   err_set_s;

    assign full_s        = (count_q == CW'(QDEPTH));
    assign empty_s       = (count_q == '0);
    // Out-of-range destinations only exist when GSIZE is not a power of two.
    assign dest_ok_s     = ({1'b0, desc_dest} < (LOG_GSIZE + 1)'(GSIZE));
    assign accept_s      = desc_valid & ~full_s;
    assign push_s        = accept_s & dest_ok_s;
    assign pop_s         = (state_q == S_IDLE) & ~empty_s;
    assign busy_s        = (state_q == S_REQ) | (state_q == S_XFER);
    assign req_vec_s     = dest_onehot(cur_dest_q);
    assign grant_cur_s   = |(grant & req_vec_s);
    assign grant_other_s = |(grant & ~req_vec_s);
    assign tx_valid_s    = (state_q == S_XFER) & grant_cur_s;
    assign beat_acc_s    = tx_valid_s & tx_ready;
    assign last_s        = (beat_q == {1'b0, cur_len_q});
    // A stray grant bit while requesting, or losing our grant mid-packet.
    assign err_set_s     = (accept_s & ~dest_ok_s)
                         | (busy_s & grant_other_s)
                         | ((state_q == S_XFER) & ~grant_cur_s);

    // req/stall depend only on registered state, never on grant or tx_ready.
    assign desc_ready = ~full_s;
    assign req        = busy_s ? req_vec_s : {GSIZE{1'b0}};
    assign stall      = (state_q == S_XFER);
    assign tx_valid   = tx_valid_s;
    assign tx_last    = tx_valid_s & last_s;
    assign pkt_cnt    = pkt_cnt_q;
    assign err        = err_q;

    // Next-state logic for the FSM, queue pointers, counters and error flag.
    always_comb begin
        state_d    = state_q;
        cur_dest_d = cur_dest_q;
        cur_len_d  = cur_len_q;
        beat_d     = beat_q;
        pkt_cnt_d  = pkt_cnt_q;
        err_d      = err_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (clr) begin
            // Flush wins over every other event this cycle; pkt_cnt survives.
            state_d  = S_IDLE;
            beat_d   = '0;
            err_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            err_d = err_q | err_set_s;
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        cur_dest_d = mem_dest_q[rd_ptr_q];
                        cur_len_d  = mem_len_q[rd_ptr_q];
                        beat_d     = '0;
                        state_d    = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_REQ: begin
                    if (grant_cur_s) begin
                        state_d = S_XFER;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_XFER: begin
                    if (beat_acc_s) begin
                        if (last_s) begin
                            state_d   = S_IDLE;
                            beat_d    = '0;
                            pkt_cnt_d = pkt_cnt_q + 16'd1;
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end else begin
                        beat_d = beat_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_dest_q <= '0;
            cur_len_q  <= '0;
            beat_q     <= '0;
            pkt_cnt_q  <= 16'd0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_dest_q <= cur_dest_d;
            cur_len_q  <= cur_len_d;
            beat_q     <= beat_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Descriptor storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s && !clr) begin
            mem_dest_q[wr_ptr_q] <= desc_dest;
            mem_len_q[wr_ptr_q]  <= desc_len;
        end
    end

endmodule
